// File: rtl/l_indication_arb.sv
// Three-input round-robin arbiter feeding one indication pipe.
// Each input has a one-beat holding buffer that can be refilled in the same cycle it drains.
module l_indication_arb #(
    parameter int WIDTH = 144
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in0_enq__ENA,
    input  logic [WIDTH-1:0] in0_enq_v,
    output logic             in0_enq__RDY,
    input  logic             in1_enq__ENA,
    input  logic [WIDTH-1:0] in1_enq_v,
    output logic             in1_enq__RDY,
    input  logic             in2_enq__ENA,
    input  logic [WIDTH-1:0] in2_enq_v,
    output logic             in2_enq__RDY,
    output logic             out_enq__ENA,
    output logic [WIDTH-1:0] out_enq_v,
    input  logic             out_enq__RDY,
    output logic [15:0]      grant_cnt
);

    logic [2:0]       buf_v_r;
    logic [WIDTH-1:0] buf_d_r [3];
    logic [1:0]       ptr_r;
    logic [15:0]      grant_cnt_r;

    logic [2:0]       ena_s;
    logic [2:0]       rdy_s;
    logic [2:0]       accept_s;
    logic [WIDTH-1:0] in_d_s [3];
    logic [1:0]       sel_s;
    logic [1:0]       cand1_s;
    logic [1:0]       cand2_s;
    logic             any_s;
    logic             fire_s;

    // Successor of an input index in the 0 -> 1 -> 2 -> 0 rotation.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        logic [1:0] res;
        case (idx)
            2'd0:    res = 2'd1;
            2'd1:    res = 2'd2;
            2'd2:    res = 2'd0;
            default: res = 2'd0;
        endcase
        return res;
    endfunction

    // Gather the per-input ports into indexable vectors.
    always_comb begin
        ena_s     = {in2_enq__ENA, in1_enq__ENA, in0_enq__ENA};
        in_d_s[0] = in0_enq_v;
        in_d_s[1] = in1_enq_v;
        in_d_s[2] = in2_enq_v;
    end

    // Round-robin selection: search starts just after the last granted input.
    always_comb begin
        cand1_s = next_idx(ptr_r);
        cand2_s = next_idx(cand1_s);
        any_s   = |buf_v_r;
        if (buf_v_r[cand1_s]) begin
            sel_s = cand1_s;
        end else if (buf_v_r[cand2_s]) begin
            sel_s = cand2_s;
        end else if (buf_v_r[ptr_r]) begin
            sel_s = ptr_r;
        end else begin
            sel_s = 2'd0;
        end
    end

    // Output handshake and bypass-refill ready; RDY never looks at any ENA.
    always_comb begin
        fire_s = any_s & out_enq__RDY & nRST;
        for (int i = 0; i < 3; i++) begin
            rdy_s[i] = nRST & (~buf_v_r[i] | (fire_s & (sel_s == i[1:0])));
        end
        accept_s = ena_s & rdy_s;
        if (any_s) begin
            out_enq_v = buf_d_r[sel_s];
        end else begin
            out_enq_v = {WIDTH{1'b0}};
        end
    end

    // Drive the remaining output ports from internal state.
    always_comb begin
        out_enq__ENA = fire_s;
        in0_enq__RDY = rdy_s[0];
        in1_enq__RDY = rdy_s[1];
        in2_enq__RDY = rdy_s[2];
        grant_cnt    = grant_cnt_r;
    end

    // Buffer valid flags, rotation pointer and grant counter.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            buf_v_r     <= 3'b000;
            ptr_r       <= 2'd2;
            grant_cnt_r <= 16'd0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (accept_s[i]) begin
                    buf_v_r[i] <= 1'b1;
                end else if (fire_s && (sel_s == i[1:0])) begin
                    buf_v_r[i] <= 1'b0;
                end else begin
                    buf_v_r[i] <= buf_v_r[i];
                end
            end
            if (fire_s) begin
                ptr_r       <= sel_s;
                grant_cnt_r <= grant_cnt_r + 16'd1;
            end else begin
                ptr_r       <= ptr_r;
                grant_cnt_r <= grant_cnt_r;
            end
        end
    end

    // Beat storage; contents only matter while the matching valid flag is set.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            if (accept_s[i]) begin
                buf_d_r[i] <= in_d_s[i];
            end else begin
                buf_d_r[i] <= buf_d_r[i];
            end
        end
    end

endmodule

// File: tb/tb_l_indication_arb.sv
// Randomized bench for l_indication_arb against a queue-per-input round-robin reference model.
module tb_l_indication_arb;
    localparam int W = 144;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   ena;
    logic [W-1:0] d0, d1, d2;
    logic         rdy0, rdy1, rdy2;
    logic         out_ena;
    logic [W-1:0] out_v;
    logic         out_rdy;
    logic [15:0]  gcnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pending beats per input (at most one each), last winner, delivered count.
    logic [W-1:0] pend [3][$];
    int           last_win;
    int           delivered;

    bit           use_fixed = 1'b0;
    logic [W-1:0] fixed_beat;

    always #5 clk = ~clk;

    l_indication_arb #(.WIDTH(W)) dut (
        .CLK          (clk),
        .nRST         (rst_n),
        .in0_enq__ENA (ena[0]),
        .in0_enq_v    (d0),
        .in0_enq__RDY (rdy0),
        .in1_enq__ENA (ena[1]),
        .in1_enq_v    (d1),
        .in1_enq__RDY (rdy1),
        .in2_enq__ENA (ena[2]),
        .in2_enq_v    (d2),
        .in2_enq__RDY (rdy2),
        .out_enq__ENA (out_ena),
        .out_enq_v    (out_v),
        .out_enq__RDY (out_rdy),
        .grant_cnt    (gcnt)
    );

    function automatic logic [W-1:0] rnd_beat();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, compare, then advance the model at posedge.
    task automatic cyc(input bit r, input bit ordy, input bit [2:0] want, input bit force_ena);
        int           win;
        bit           e_ena;
        logic [W-1:0] e_v;
        bit   [2:0]   e_rdy;
        logic [W-1:0] nd [3];
        @(negedge clk);
        win = -1;
        for (int k = 1; k <= 3; k++) begin
            if (win < 0 && pend[(last_win + k) % 3].size() > 0) win = (last_win + k) % 3;
        end
        e_ena = (win >= 0) && ordy && r;
        e_v   = (win >= 0) ? pend[win][0] : '0;
        for (int x = 0; x < 3; x++) begin
            e_rdy[x] = r && (pend[x].size() == 0 || (e_ena && win == x));
            nd[x]    = (use_fixed && x == 0) ? fixed_beat : rnd_beat();
        end
        rst_n   = r;
        out_rdy = ordy;
        ena     = force_ena ? want : (want & e_rdy);
        d0 = nd[0]; d1 = nd[1]; d2 = nd[2];
        #1;
        check("rdy", {{(W-3){1'b0}}, rdy2, rdy1, rdy0}, {{(W-3){1'b0}}, e_rdy});
        check("out_ena", {{(W-1){1'b0}}, out_ena}, {{(W-1){1'b0}}, e_ena});
        check("out_v", out_v, e_v);
        check("grant_cnt", {{(W-16){1'b0}}, gcnt}, W'(delivered % 65536));
        @(posedge clk);
        if (!r) begin
            for (int x = 0; x < 3; x++) pend[x].delete();
            last_win  = 2;
            delivered = 0;
        end else begin
            if (e_ena) begin
                void'(pend[win].pop_front());
                last_win = win;
                delivered++;
            end
            for (int x = 0; x < 3; x++) begin
                if (ena[x]) pend[x].push_back(nd[x]);
            end
        end
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; out_rdy = 1'b1; ena = 3'b000;
        d0 = '0; d1 = '0; d2 = '0;
        last_win = 2; delivered = 0;
        fixed_beat = '0;
        fixed_beat[143:128] = 16'h0001;
        fixed_beat[7:0]     = 8'hAA;

        // Reset with every ENA forced high, then one directed beat on in0.
        cyc(1'b0, 1'b1, 3'b111, 1'b1);
        cyc(1'b0, 1'b1, 3'b111, 1'b1);
        use_fixed = 1'b1;
        cyc(1'b1, 1'b1, 3'b001, 1'b0);
        use_fixed = 1'b0;
        cyc(1'b1, 1'b1, 3'b000, 1'b0);
        #1 check("first_cnt", {{(W-16){1'b0}}, gcnt}, W'(1));

        // Single-input streaming on in1.
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, (i < 8) ? 3'b010 : 3'b000, 1'b0);

        // Three-way contention from a fresh reset: expect 0,1,2 rotation.
        cyc(1'b0, 1'b1, 3'b000, 1'b0);
        for (int i = 0; i < 13; i++) cyc(1'b1, 1'b1, 3'b111, 1'b0);
        #1 check("contend_cnt", {{(W-16){1'b0}}, gcnt}, W'(12));

        // Backpressure: buffers full and held for 5 cycles, then release.
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 3'b111, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 3'b000, 1'b0);

        // Reset pulse with full, stalled buffers; in0 must win first afterward.
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 3'b111, 1'b0);
        cyc(1'b0, 1'b0, 3'b000, 1'b0);
        cyc(1'b1, 1'b1, 3'b000, 1'b0);
        cyc(1'b1, 1'b0, 3'b111, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 3'b000, 1'b0);

        // Randomized traffic with occasional resets and backpressure.
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 59) != 0, $urandom_range(0, 3) != 0,
                3'($urandom_range(0, 7)), 1'b0);

        // Counter wrap: stream on in0 until 0xFFFF, then two more fires.
        cyc(1'b0, 1'b1, 3'b000, 1'b0);
        guard = 0;
        while (delivered != 65535 && guard < 70000) begin
            cyc(1'b1, 1'b1, 3'b001, 1'b0);
            guard++;
        end
        #1 check("wrap_ffff", {{(W-16){1'b0}}, gcnt}, W'(16'hFFFF));
        cyc(1'b1, 1'b1, 3'b001, 1'b0);
        #1 check("wrap_0000", {{(W-16){1'b0}}, gcnt}, W'(16'h0000));
        cyc(1'b1, 1'b1, 3'b001, 1'b0);
        #1 check("wrap_0001", {{(W-16){1'b0}}, gcnt}, W'(16'h0001));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/l_indication_arb.md
# l_indication_arb

Three-input round-robin arbiter that shares one outbound indication pipe (16-bit header + 128-bit payload) among three method-to-pipe serializers. It sits between the serializer `pipe$enq` outputs and the top-level `indication$enq` port. Each input has a one-entry holding buffer, so input `__RDY` never depends on that input's own `__ENA`. Beats are forwarded unmodified. Each input's order is preserved, and no input can be starved.

## Interface
- `WIDTH`, default 144: beat width, `16 + 128`; header in bits [143:128], payload in [127:0]
- `CLK`  in  1: single clock; all state updates on the rising edge
- `nRST`  in  1: reset, synchronous and active-low; sampled on the `CLK` rising edge
- `in0$enq__ENA`  in  1: beat offered on input 0; asserted only while `in0$enq__RDY` is high
- `in0$enq$v`  in  WIDTH: input 0 beat
- `in0$enq__RDY`  out  1: input 0 can accept a beat this cycle
- `in1$enq__ENA`, `in1$enq$v`, `in1$enq__RDY`: as for input 0, for input 1
- `in2$enq__ENA`, `in2$enq$v`, `in2$enq__RDY`: as for input 0, for input 2
- `out$enq__ENA`  out  1: beat delivered downstream this cycle
- `out$enq$v`  out  WIDTH: delivered beat
- `out$enq__RDY`  in  1: downstream can accept
- `grant_cnt`  out  16: count of beats delivered, wraps modulo 2^16

## Operation
- State:
  - `buf_v[2:0]` and `buf_d[i]` (WIDTH each): one holding buffer per input
  - `ptr[1:0]` in {0,1,2}: index of the last input granted
  - `grant_cnt`
- Arbitration, combinational from registered state:
  - Candidates are the inputs with `buf_v[i]` set.
  - Priority order is `ptr+1`, `ptr+2`, `ptr`, all modulo 3; the first valid candidate is `sel`.
  - `any = |buf_v`.
- Output: `out$enq__ENA = any & out$enq__RDY & nRST`; `out$enq$v = buf_d[sel]`.
  - When `any` is 0, `out$enq$v` is 0 (no X propagation).
- Fire: `fire = out$enq__ENA`. On fire:
  - `buf_v[sel]` clears unless refilled in the same cycle
  - `ptr <= sel`
  - `grant_cnt <= grant_cnt + 1`, wrapping from 0xFFFF to 0x0000
- Input ready: `inX$enq__RDY = nRST & (!buf_v[X] | (fire & sel==X))`.
  - This is a bypass refill, so one input alone sustains one beat per cycle.
  - RDY depends combinationally on `out$enq__RDY` only, never on any `__ENA`.
- On `inX$enq__ENA`: `buf_d[X] <= inX$enq$v` and `buf_v[X] <= 1`.
- Same-cycle drain and refill of buffer X: the new data is loaded, `buf_v[X]` stays 1, and the old beat is the one output this cycle.
- The header is not decoded. Multi-beat messages are the serializer's concern.
  - Each serializer emits whole messages into its own input, so per-input ordering is sufficient.
  - Interleaving between inputs is allowed and expected.
- Reset, when `nRST` is 0 at a rising edge:
  - `buf_v <= 0`
  - `ptr <= 2`, so input 0 has first priority
  - `grant_cnt <= 0`
  - `buf_d` is don't-care
  - Reset mid-transfer drops all buffered beats; nothing is delivered after reset from pre-reset state.

## Timing
- While `nRST` is low, all `__RDY` outputs and `out$enq__ENA` are 0.
  - After reset, `out$enq$v` = 0 and `grant_cnt` = 0.
- Latency: a beat accepted at edge N is presentable on `out` in cycle N+1. It fires in that cycle if it wins arbitration and `out$enq__RDY` is 1.
- Throughput:
  - One beat per cycle total.
  - With k inputs continuously busy, each gets exactly 1/k of the slots, in strict rotation.
- Backpressure: while `out$enq__RDY` is 0:
  - the buffers hold
  - `ptr` and `grant_cnt` are frozen
  - an input's RDY is 1 only if its buffer is empty
- Worst-case wait for a valid buffer is 2 grants of other inputs.

## Test plan
- **Reset values:** hold `nRST`=0 for 2 cycles with all ENA high attempted → all RDY = 0, `out$enq__ENA` = 0, `grant_cnt` = 0. Release, then enq 0x0001_…_AA on in0 → `out$enq$v` equals it 1 cycle later, and `grant_cnt` = 1.
- **Single-input streaming:** stream 8 beats on in1 with `out$enq__RDY` held 1 → 8 consecutive output beats in order, one per cycle, `in1$enq__RDY` constantly 1.
- **Three-way contention:** all three inputs enqueue each cycle → output source order 0,1,2,0,1,2… and `grant_cnt` = 12 after 12 fires.
- **Backpressure:** fill all buffers, then hold `out$enq__RDY`=0 for 5 cycles → no fire, all RDY = 0, buffers unchanged. Release → delivery resumes at priority `ptr+1`.
- **Counter wrap:** preload via 65535 fires, then 2 more → `grant_cnt` reads 0xFFFF, then 0x0000, then 0x0001.
- **Reset mid-operation:** buffers full and stalled, pulse `nRST`=0 for 1 cycle → afterward no stale beat appears on `out`, `ptr` restarts so in0 wins first, and `grant_cnt` = 0.
